noaa_stats_engine: RTL and testbench

Parametrised multi-channel successor to the NOAA IoT mote statistics module. It accepts temperature samples for CH independent channels and accumulates a window of N samples per channel. When a window completes, it emits one statistic for that channel: average, standard deviation, minimum or maximum. It sits between the mote sample front-end and the uplink packer, and shares a single result engine (with an iterative integer square root) across all channels.

---
 rtl/noaa_pkg.sv | 23 ++
 rtl/noaa_isqrt.sv | 71 +++++++
 rtl/noaa_stats_engine.sv | 194 +++++++++++++++++++
 tb/tb_noaa_stats_engine.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noaa_pkg.sv
// Shared encodings and width helpers for the NOAA multi-channel statistics engine.
package noaa_pkg;

    localparam logic [1:0] MODE_AVG = 2'b00;
    localparam logic [1:0] MODE_SD  = 2'b01;
    localparam logic [1:0] MODE_MIN = 2'b10;
    localparam logic [1:0] MODE_MAX = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StRoot
    } state_e;

    function automatic int unsigned sum_width(input int unsigned w, input int unsigned n);
        return w + $clog2(n);
    endfunction

    function automatic int unsigned sumsq_width(input int unsigned w, input int unsigned n);
        return 2 * w + $clog2(n);
    endfunction

endpackage

// File: rtl/noaa_isqrt.sv
// Iterative restoring integer square root: one result bit per cycle, W cycles per root.
module noaa_isqrt #(
    parameter int unsigned W = 12
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           start_i,
    input  logic [2*W-1:0] radicand_i,
    output logic [W-1:0]   root_o,
    output logic           valid_o
);

    localparam int unsigned RW  = W + 2;
    localparam int unsigned CNW = $clog2(W + 1);

    logic [2*W-1:0] rad_q, rad_d;
    logic [RW-1:0]  rem_q, rem_d;
    logic [W-1:0]   root_q, root_d;
    logic [CNW-1:0] cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic [RW+1:0]  rem_sh, trial;

    always_comb begin
        rad_d  = rad_q;
        rem_d  = rem_q;
        root_d = root_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        rem_sh = {rem_q, rad_q[2*W-1 -: 2]};
        trial  = {2'b00, root_q, 2'b01};
        if (start_i) begin
            rad_d  = radicand_i;
            rem_d  = '0;
            root_d = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            rad_d = rad_q << 2;
            if (rem_sh >= trial) begin
                rem_d  = RW'(rem_sh - trial);
                root_d = {root_q[W-2:0], 1'b1};
            end else begin
                rem_d  = RW'(rem_sh);
                root_d = {root_q[W-2:0], 1'b0};
            end
            cnt_d  = cnt_q + CNW'(1);
            busy_d = (cnt_q != CNW'(W - 1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rad_q  <= rad_d;
            rem_q  <= rem_d;
            root_q <= root_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // The final bit is resolved combinationally so the caller can register it on this edge.
    assign valid_o = busy_q && (cnt_q == CNW'(W - 1));
    assign root_o  = root_d;

endmodule

// File: rtl/noaa_stats_engine.sv
// Per-channel window accumulators feeding one shared avg/sd/min/max result engine.
module noaa_stats_engine
    import noaa_pkg::*;
#(
    parameter int unsigned W  = 12,
    parameter int unsigned N  = 8,
    parameter int unsigned CH = 4,
    localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [W-1:0]  tn_i,
    input  logic [CW-1:0] tn_ch_i,
    input  logic          tn_valid_i,
    input  logic [1:0]    mode_i,
    output logic          sample_o,
    output logic          done_o,
    output logic [W-1:0]  avg_sd_o,
    output logic [CW-1:0] out_ch_o
);

    localparam int unsigned LN = $clog2(N);
    localparam int unsigned NW = LN + 1;
    localparam int unsigned SW = sum_width(W, N);
    localparam int unsigned QW = sumsq_width(W, N);
    localparam int unsigned W2 = 2 * W;

    logic [SW-1:0] sum_q   [CH];
    logic [QW-1:0] sumsq_q [CH];
    logic [W-1:0]  min_q   [CH];
    logic [W-1:0]  max_q   [CH];
    logic [NW-1:0] cnt_q   [CH];
    logic [1:0]    mode_q  [CH];
    logic [CH-1:0] pend_q;

    logic          ch_ok, accept, pend_any, snap, sqrt_start, sqrt_valid;
    logic [CW-1:0] sel_ch;
    logic [W2-1:0] tn_sq;
    logic [W-1:0]  sqrt_root;

    assign ch_ok    = 32'(tn_ch_i) < CH;
    assign sample_o = rst_ni && ch_ok && !pend_q[tn_ch_i];
    assign accept   = tn_valid_i && sample_o;
    assign tn_sq    = W2'(tn_i) * W2'(tn_i);

    always_comb begin
        pend_any = 1'b0;
        sel_ch   = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                pend_any = 1'b1;
                sel_ch   = CW'(i);
            end
        end
    end

    // A snapshotted channel is pending, so it can never also accept a sample on that edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < CH; i++) begin
                sum_q[i]   <= '0;
                sumsq_q[i] <= '0;
                min_q[i]   <= '1;
                max_q[i]   <= '0;
                cnt_q[i]   <= '0;
                mode_q[i]  <= MODE_AVG;
            end
            pend_q <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (snap && sel_ch == CW'(i)) begin
                    sum_q[i]   <= '0;
                    sumsq_q[i] <= '0;
                    min_q[i]   <= '1;
                    max_q[i]   <= '0;
                    cnt_q[i]   <= '0;
                    pend_q[i]  <= 1'b0;
                end else if (accept && tn_ch_i == CW'(i)) begin
                    sum_q[i]   <= sum_q[i] + SW'(tn_i);
                    sumsq_q[i] <= sumsq_q[i] + QW'(tn_sq);
                    if (tn_i < min_q[i]) min_q[i] <= tn_i;
                    if (tn_i > max_q[i]) max_q[i] <= tn_i;
                    cnt_q[i] <= cnt_q[i] + NW'(1);
                    if (cnt_q[i] == NW'(N - 1)) begin
                        pend_q[i] <= 1'b1;
                        mode_q[i] <= mode_i;
                    end
                end
            end
        end
    end

    state_e        state_q, state_d;
    logic [SW-1:0] wk_sum_q;
    logic [QW-1:0] wk_sumsq_q;
    logic [W-1:0]  wk_min_q, wk_max_q;
    logic [1:0]    wk_mode_q;
    logic [CW-1:0] wk_ch_q;
    logic          done_q, done_d;
    logic [W-1:0]  res_q, res_d;
    logic [CW-1:0] och_q, och_d;
    logic [W-1:0]  avg;
    logic [W2-1:0] mean_sq, avg_sq, var_w;

    assign avg     = W'(wk_sum_q >> LN);
    assign mean_sq = W2'(wk_sumsq_q >> LN);
    assign avg_sq  = W2'(avg) * W2'(avg);
    assign var_w   = mean_sq - avg_sq;

    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        res_d      = res_q;
        och_d      = och_q;
        snap       = 1'b0;
        sqrt_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pend_any) begin
                    snap    = 1'b1;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (wk_mode_q == MODE_SD) begin
                    sqrt_start = 1'b1;
                    state_d    = StRoot;
                end else begin
                    case (wk_mode_q)
                        MODE_MIN: res_d = wk_min_q;
                        MODE_MAX: res_d = wk_max_q;
                        default:  res_d = avg;
                    endcase
                    done_d  = 1'b1;
                    och_d   = wk_ch_q;
                    state_d = StIdle;
                end
            end
            StRoot: begin
                if (sqrt_valid) begin
                    res_d   = sqrt_root;
                    done_d  = 1'b1;
                    och_d   = wk_ch_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            done_q     <= 1'b0;
            res_q      <= '0;
            och_q      <= '0;
            wk_sum_q   <= '0;
            wk_sumsq_q <= '0;
            wk_min_q   <= '0;
            wk_max_q   <= '0;
            wk_mode_q  <= MODE_AVG;
            wk_ch_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            res_q   <= res_d;
            och_q   <= och_d;
            if (snap) begin
                wk_sum_q   <= sum_q[sel_ch];
                wk_sumsq_q <= sumsq_q[sel_ch];
                wk_min_q   <= min_q[sel_ch];
                wk_max_q   <= max_q[sel_ch];
                wk_mode_q  <= mode_q[sel_ch];
                wk_ch_q    <= sel_ch;
            end
        end
    end

    noaa_isqrt #(
        .W(W)
    ) u_isqrt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .start_i   (sqrt_start),
        .radicand_i(var_w),
        .root_o    (sqrt_root),
        .valid_o   (sqrt_valid)
    );

    assign done_o   = done_q;
    assign avg_sd_o = res_q;
    assign out_ch_o = och_q;

endmodule

// File: tb/tb_noaa_stats_engine.sv
// Scoreboard bench for noaa_stats_engine (W=12, N=8, CH=4): expected results queued at stimulus time.
module tb_noaa_stats_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tn_valid = 1'b0;
    logic [11:0] tn = '0;
    logic [1:0]  tn_ch = '0;
    logic [1:0]  mode = '0;
    logic        sample, done;
    logic [11:0] avg_sd;
    logic [1:0]  out_ch;

    typedef struct {
        int ch;
        int val;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   acc_cyc[4];
    bit   prev_done = 1'b0;
    int   win[8];

    noaa_stats_engine #(
        .W (12),
        .N (8),
        .CH(4)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .tn_i      (tn),
        .tn_ch_i   (tn_ch),
        .tn_valid_i(tn_valid),
        .mode_i    (mode),
        .sample_o  (sample),
        .done_o    (done),
        .avg_sd_o  (avg_sd),
        .out_ch_o  (out_ch)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model(input int w[8], input int m);
        int s, sq, mn, mx, avg, v, r;
        s = 0; sq = 0; mn = 4095; mx = 0;
        for (int i = 0; i < 8; i++) begin
            s  += w[i];
            sq += w[i] * w[i];
            if (w[i] < mn) mn = w[i];
            if (w[i] > mx) mx = w[i];
        end
        avg = s / 8;
        case (m)
            0: return avg;
            1: begin
                v = sq / 8 - avg * avg;
                r = 0;
                while ((r + 1) * (r + 1) <= v) r++;
                return r;
            end
            2: return mn;
            default: return mx;
        endcase
    endfunction

    // Result monitor: pops the scoreboard on every DONE.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                done_cnt++;
                if (prev_done) check_eq("done back-to-back", 1, 0);
                if (sb.size() == 0) begin
                    check_eq("unexpected done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("result", int'(avg_sd), e.val);
                    check_eq("out_ch", int'(out_ch), e.ch);
                    if (e.lat != 0) check_eq("done latency", cyc - acc_cyc[e.ch], e.lat);
                end
            end
            prev_done = done;
        end
    end

    task automatic send(input int ch, input int val, input int m);
        bit ok;
        ok = 1'b0;
        tn_ch = 2'(ch);
        tn = 12'(val);
        mode = 2'(m);
        tn_valid = 1'b1;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (sample) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (ok) acc_cyc[ch] = cyc;
        else check_eq("send timeout", 0, 1);
        tn_valid = 1'b0;
    endtask

    // Earlier samples carry a different MODE, which must be ignored.
    task automatic send_win(input int ch, input int w[8], input int m, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send(ch, w[i], (i == 7) ? m : (m + 1) % 4);
    endtask

    task automatic push(input int ch, input int val, input int lat);
        exp_t e;
        e.ch = ch; e.val = val; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check_eq("results outstanding", sb.size(), 0);
        sb.delete();
    endtask

    task automatic probe(input int ch, input int exp, input int cycles, input string tag);
        tn_ch = 2'(ch);
        tn = 12'd9;
        tn_valid = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            check_eq(tag, int'(sample), exp);
            @(posedge clk);
            #1;
        end
        tn_valid = 1'b0;
    endtask

    initial begin
        int base;
        // Reset with traffic applied
        tn_valid = 1'b1; tn = 12'd77; tn_ch = 2'd1;
        repeat (2) begin
            @(negedge clk);
            check_eq("reset done", int'(done), 0);
            check_eq("reset avg_sd", int'(avg_sd), 0);
            check_eq("reset out_ch", int'(out_ch), 0);
            check_eq("reset sample", int'(sample), 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tn_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_eq("no done after reset", done_cnt, 0);

        // Average
        win = '{10, 11, 12, 13, 14, 15, 16, 17};
        push(0, model(win, 0), 2);
        send_win(0, win, 0, 0, 7);
        drain(40);

        // Standard deviation
        win = '{2, 4, 4, 4, 5, 5, 7, 9};
        push(1, model(win, 1), 14);
        send_win(1, win, 1, 0, 7);
        drain(40);

        // Extremes and fresh accumulators
        win = '{4095, 0, 1, 2, 3, 4, 5, 6};
        push(2, model(win, 3), 2);
        send_win(2, win, 3, 0, 7);
        drain(40);
        win = '{7, 0, 9, 3, 4, 5, 6, 8};
        push(2, model(win, 2), 2);
        send_win(2, win, 2, 0, 7);
        drain(40);
        win = '{50, 51, 52, 53, 54, 55, 56, 57};
        push(2, model(win, 2), 2);
        send_win(2, win, 2, 0, 7);
        drain(40);
        win = '{20, 21, 22, 23, 24, 25, 26, 27};
        push(2, model(win, 3), 2);
        send_win(2, win, 3, 0, 7);
        drain(40);

        // Contention: ch1 SD, then ch3/ch0 complete during ROOT
        win = '{10, 20, 30, 40, 50, 60, 70, 80};
        push(1, model(win, 1), 14);
        send_win(1, win, 1, 0, 6);
        begin
            int w3[8], w0[8];
            w3 = '{100, 101, 102, 103, 104, 105, 106, 107};
            w0 = '{30, 31, 32, 33, 34, 35, 36, 37};
            push(0, model(w0, 2), 0);
            push(3, model(w3, 0), 0);
            send_win(3, w3, 0, 0, 6);
            send_win(0, w0, 2, 0, 6);
            send_win(1, win, 1, 7, 7);
            send_win(3, w3, 0, 7, 7);
            send_win(0, w0, 2, 7, 7);
        end
        probe(3, 0, 2, "ch3 stalled");
        probe(0, 0, 2, "ch0 stalled");
        probe(2, 1, 3, "ch2 ready");
        drain(100);

        // Reset mid-ROOT, with a partial ch0 window in flight
        send(0, 200, 0);
        send(0, 200, 0);
        send(0, 200, 0);
        win = '{2, 4, 4, 4, 5, 5, 7, 9};
        send_win(1, win, 1, 0, 7);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = done_cnt;
        repeat (25) @(posedge clk);
        #1;
        check_eq("no done after mid-root reset", done_cnt - base, 0);
        win = '{100, 200, 300, 400, 500, 600, 700, 800};
        push(0, model(win, 0), 2);
        send_win(0, win, 0, 0, 7);
        drain(40);
        win = '{2, 4, 4, 4, 5, 5, 7, 9};
        push(1, model(win, 1), 14);
        send_win(1, win, 1, 0, 7);
        drain(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
